// File: rtl/imem_loader.sv
// imem_loader: receives a program as a byte stream and writes it, word by word,
// into the instruction memory's write port.
//
// Stream format: 2-byte big-endian word count N, then N big-endian 32-bit words.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   start_in             one-cycle load request, sampled only in IDLE
//   byte_in/valid/ready  byte stream handshake (transfer = valid & ready)
//   write_enable_out     one-cycle write strobe
//   write_address_out    word address for the write (held between writes)
//   write_data_out       instruction word for the write (held between writes)
//   busy_out             a load is in progress
//   done_out             one-cycle pulse on successful completion
//   error_out            sticky error (oversize length or timeout)
//   word_count_out       words written in the current or last load
module imem_loader #(
    parameter int unsigned MEM_SIZE       = 256,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_in,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid_in,
    output logic        byte_ready_out,
    output logic        write_enable_out,
    output logic [31:0] write_address_out,
    output logic [31:0] write_data_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        error_out,
    output logic [15:0] word_count_out
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, WRITE, FINISH
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] len_q;
    logic [1:0]  byte_idx;
    logic [31:0] word_asm;
    logic [31:0] idle_cnt;

    logic        xfer;
    logic        timeout;
    logic        oversize;
    logic [15:0] len_full;
    logic [15:0] count_inc;
    logic [31:0] asm_nxt;

    assign xfer      = byte_valid_in && byte_ready_out;
    assign len_full  = {len_q[15:8], byte_in};
    assign oversize  = 32'(len_full) > MEM_SIZE;
    assign count_inc = word_count_out + 16'd1;
    assign asm_nxt   = {word_asm[23:0], byte_in};

    // Ready is high exactly in the states that wait for bytes, so it doubles
    // as the "waiting" qualifier for the idle counter.
    assign timeout = (TIMEOUT_CYCLES != 0) && byte_ready_out && !xfer &&
                     (idle_cnt == TIMEOUT_CYCLES - 1);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start_in) state_nxt = LEN_HI;
            LEN_HI: begin
                if (timeout)   state_nxt = IDLE;
                else if (xfer) state_nxt = LEN_LO;
            end
            LEN_LO: begin
                if (timeout) state_nxt = IDLE;
                else if (xfer) begin
                    if (len_full == 16'd0) state_nxt = FINISH;
                    else if (oversize)     state_nxt = IDLE;
                    else                   state_nxt = DATA;
                end
            end
            DATA: begin
                if (timeout)                         state_nxt = IDLE;
                else if (xfer && byte_idx == 2'd3)   state_nxt = WRITE;
            end
            WRITE:  state_nxt = (count_inc == len_q) ? FINISH : DATA;
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        byte_ready_out   = 1'b0;
        busy_out         = 1'b0;
        write_enable_out = 1'b0;
        done_out         = 1'b0;
        case (state)
            LEN_HI, LEN_LO, DATA: begin
                byte_ready_out = 1'b1;
                busy_out       = 1'b1;
            end
            WRITE: begin
                busy_out         = 1'b1;
                write_enable_out = 1'b1;
            end
            FINISH:  done_out = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q             <= '0;
            byte_idx          <= '0;
            word_asm          <= '0;
            idle_cnt          <= '0;
            error_out         <= 1'b0;
            word_count_out    <= '0;
            write_address_out <= '0;
            write_data_out    <= '0;
        end else begin
            // Idle counter: cleared on every transfer and when a load starts,
            // advanced only while waiting for a byte that does not come.
            if ((state == IDLE && start_in) || xfer) idle_cnt <= '0;
            else if (byte_ready_out)                 idle_cnt <= idle_cnt + 32'd1;

            if (timeout) error_out <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_in) begin
                        error_out      <= 1'b0;
                        word_count_out <= '0;
                    end
                end
                LEN_HI: if (xfer) len_q[15:8] <= byte_in;
                LEN_LO: begin
                    if (xfer) begin
                        len_q[7:0] <= byte_in;
                        byte_idx   <= '0;
                        if (len_full != 16'd0 && oversize) error_out <= 1'b1;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        word_asm <= asm_nxt;
                        byte_idx <= byte_idx + 2'd1;
                        // Capture address/data on the last byte so they are
                        // stable through the WRITE cycle and held afterwards.
                        if (byte_idx == 2'd3) begin
                            write_address_out <= BASE_ADDR + 32'(word_count_out);
                            write_data_out    <= asm_nxt;
                        end
                    end
                end
                WRITE:   word_count_out <= count_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed byte streams, expected writes and done
// pulses queued by the stimulus, checked by an independent monitor.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_in = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid_in = 1'b0;
    logic        byte_ready_out;
    logic        write_enable_out;
    logic [31:0] write_address_out;
    logic [31:0] write_data_out;
    logic        busy_out;
    logic        done_out;
    logic        error_out;
    logic [15:0] word_count_out;

    int tests = 0;
    int fails = 0;

    logic [63:0] exp_wr[$];    // {addr, data}
    logic [15:0] exp_done[$];  // word_count at done

    imem_loader #(.MEM_SIZE(256), .BASE_ADDR(0), .TIMEOUT_CYCLES(20)) dut (
        .clk               (clk),
        .reset             (reset),
        .start_in          (start_in),
        .byte_in           (byte_in),
        .byte_valid_in     (byte_valid_in),
        .byte_ready_out    (byte_ready_out),
        .write_enable_out  (write_enable_out),
        .write_address_out (write_address_out),
        .write_data_out    (write_data_out),
        .busy_out          (busy_out),
        .done_out          (done_out),
        .error_out         (error_out),
        .word_count_out    (word_count_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe and done pulse is matched against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (write_enable_out) begin
                chk("ready_low_in_write", 32'(byte_ready_out), 32'd0);
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_wr.pop_front();
                    chk("write_addr", write_address_out, e[63:32]);
                    chk("write_data", write_data_out, e[31:0]);
                end
            end
            if (done_out) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [15:0] c;
                    c = exp_done.pop_front();
                    chk("done_count", 32'(word_count_out), 32'(c));
                    chk("done_error", 32'(error_out), 32'd0);
                end
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1 start_in = 1'b1;
        @(posedge clk); #1 start_in = 1'b0;
    endtask

    // Present one byte, hold it until accepted, then optionally drop valid
    // for 'gap' cycles. With gap=0 valid stays high into the next byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid_in = 1'b1;
        byte_in = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (byte_ready_out) break;
            n++;
            if (n > 50) begin
                chk("byte_accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        if (gap > 0) begin
            byte_valid_in = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_in();
        byte_valid_in = 1'b0;
        byte_in = 8'h00;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (done_out) break;
            n++;
            if (n > budget) begin
                chk(name, 32'd0, 32'd1);
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] bp_bytes[14];
        int         bp_gaps[14];
        bp_bytes = '{8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02,
                     8'h03, 8'h04, 8'hFF, 8'hEE, 8'h00, 8'h80};
        bp_gaps  = '{0, 3, 0, 7, 1, 0, 0, 5, 2, 0, 6, 0, 4, 0};

        // Reset state
        #1 reset = 1'b1;
        #2;
        chk("rst_ready", 32'(byte_ready_out), 0);
        chk("rst_we",    32'(write_enable_out), 0);
        chk("rst_busy",  32'(busy_out), 0);
        chk("rst_done",  32'(done_out), 0);
        chk("rst_error", 32'(error_out), 0);
        chk("rst_addr",  write_address_out, 0);
        chk("rst_data",  write_data_out, 0);
        chk("rst_count", 32'(word_count_out), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Normal load of two words
        exp_wr.push_back({32'd0, 32'h24080005});
        exp_wr.push_back({32'd1, 32'h0000000C});
        exp_done.push_back(16'd2);
        do_start();
        chk("lenhi_busy",  32'(busy_out), 1);
        chk("lenhi_ready", 32'(byte_ready_out), 1);
        foreach (bp_gaps[i]) if (i < 10) begin
            logic [7:0] nb[10];
            nb = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
            send_byte(nb[i], 0);
        end
        idle_in();
        wait_done("normal_done_seen", 10);
        @(negedge clk);
        chk("normal_count", 32'(word_count_out), 2);
        chk("normal_error", 32'(error_out), 0);
        chk("normal_busy",  32'(busy_out), 0);

        // Zero length
        exp_done.push_back(16'd0);
        do_start();
        chk("zero_count_cleared", 32'(word_count_out), 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        idle_in();
        wait_done("zero_done_seen", 3);
        @(negedge clk);
        chk("zero_count", 32'(word_count_out), 0);

        // Oversize length 257
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        idle_in();
        repeat (3) @(negedge clk);
        chk("over_error", 32'(error_out), 1);
        chk("over_busy",  32'(busy_out), 0);
        chk("over_ready", 32'(byte_ready_out), 0);
        chk("over_count", 32'(word_count_out), 0);

        // Backpressure: valid held high across WRITE cycles, plus gaps
        exp_wr.push_back({32'd0, 32'hDEADBEEF});
        exp_wr.push_back({32'd1, 32'h01020304});
        exp_wr.push_back({32'd2, 32'hFFEE0080});
        exp_done.push_back(16'd3);
        do_start();
        chk("start_clears_error", 32'(error_out), 0);
        foreach (bp_bytes[i]) send_byte(bp_bytes[i], bp_gaps[i]);
        idle_in();
        wait_done("bp_done_seen", 10);
        @(negedge clk);
        chk("bp_count", 32'(word_count_out), 3);

        // Timeout after one full word and a partial one
        exp_wr.push_back({32'd0, 32'hA1B2C3D4});
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'hA1, 0);
        send_byte(8'hB2, 0);
        send_byte(8'hC3, 0);
        send_byte(8'hD4, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        idle_in();
        repeat (25) @(negedge clk);
        chk("to_error", 32'(error_out), 1);
        chk("to_count", 32'(word_count_out), 1);
        chk("to_busy",  32'(busy_out), 0);
        chk("to_data_held", write_data_out, 32'hA1B2C3D4);

        // Reset mid-load between 2nd and 3rd data bytes
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        idle_in();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy",  32'(busy_out), 0);
        chk("mid_rst_ready", 32'(byte_ready_out), 0);
        chk("mid_rst_data",  write_data_out, 0);
        chk("mid_rst_count", 32'(word_count_out), 0);
        chk("mid_rst_error", 32'(error_out), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_wr.push_back({32'd0, 32'h11223344});
        exp_done.push_back(16'd1);
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        idle_in();
        wait_done("fresh_done_seen", 10);
        @(negedge clk);
        chk("fresh_count", 32'(word_count_out), 1);

        repeat (3) @(negedge clk);
        chk("writes_left", 32'(exp_wr.size()), 0);
        chk("dones_left",  32'(exp_done.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
